// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write signals of the program loader.
// master = loader side, slave = byte source / memory side.
interface imem_program_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_program_loader.sv
// Loads big-endian 32-bit instructions from a byte stream into consecutive
// instruction-memory words from address 0, stalling fetch for the whole load.
module imem_program_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W:0]       word_count,
    imem_program_loader_if.master bus,
    output logic                  fetch_hold,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W:0]   n_words;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        byte_cnt;
    // Holds the first three bytes; the fourth goes straight into mem_wdata so
    // mem_wdata keeps the last written word while the next one is assembled.
    logic [DATA_W-9:0] asm_bytes;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            n_words        <= '0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            asm_bytes      <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            fetch_hold     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_words    <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                        word_idx   <= '0;
                        byte_cnt   <= '0;
                        fetch_hold <= 1'b1;
                        busy       <= 1'b1;
                        if (word_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state          <= COLLECT;
                            bus.byte_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid && bus.byte_ready) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            state          <= WRITE;
                            bus.byte_ready <= 1'b0;
                            bus.mem_we     <= 1'b1;
                            bus.mem_addr   <= word_idx;
                            bus.mem_wdata  <= {asm_bytes, bus.byte_in};
                        end else begin
                            asm_bytes <= {asm_bytes[DATA_W-17:0], bus.byte_in};
                        end
                    end
                end
                WRITE: begin
                    bus.mem_we <= 1'b0;
                    if ({1'b0, word_idx} == n_words - 1'b1) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state          <= COLLECT;
                        word_idx       <= word_idx + 1'b1;
                        byte_cnt       <= '0;
                        bus.byte_ready <= 1'b1;
                    end
                end
                FINISH: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    fetch_hold <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a table of whole-load vectors plus
// hand-written cycle sequences for timing, reset-abort and ignored-start cases.
module tb_imem_program_loader;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] word_count;
    logic       fetch_hold, busy, done;

    imem_program_loader_if #(.ADDR_W(4), .DATA_W(32)) bus ();

    imem_program_loader #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .bus        (bus),
        .fetch_hold (fetch_hold),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  wc;
        logic [31:0] base;
        logic [31:0] step;
        bit          gaps;
        int          exp_writes;
    } vec_t;

    vec_t vecs[6];

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    int          done_cnt   = 0;
    bit          ready_seen = 0;
    logic        prev_we    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wq_addr.push_back(bus.mem_addr);
            wq_data.push_back(bus.mem_wdata);
        end
        if (done === 1'b1) done_cnt++;
        if (bus.byte_ready === 1'b1) ready_seen = 1;
        if (reset === 1'b0) begin
            check("hold_eq_busy", {31'd0, fetch_hold}, {31'd0, busy});
            if (prev_we === 1'b1) check("we_single_pulse", {31'd0, bus.mem_we}, 32'd0);
        end
        prev_we = bus.mem_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq_addr.delete();
        wq_data.delete();
        done_cnt   = 0;
        ready_seen = 0;
    endtask

    task automatic pulse_start(input logic [4:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        guard = 0;
        @(negedge clk);
        while (bus.byte_ready !== 1'b1 && guard < 100) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 100) check("byte_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int unsigned k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gaps);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done_cnt == 0 && guard < 30) begin
            guard++;
            tick();
        end
        if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    function automatic logic [31:0] word_data(input vec_t v, input int i);
        return v.base + v.step * 32'(i);
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        clear_log();
        pulse_start(v.wc);
        for (int i = 0; i < v.exp_writes; i++) send_word(word_data(v, i), v.gaps);
        wait_done();
        check($sformatf("v%0d_writes", idx), wq_addr.size(), v.exp_writes);
        for (int i = 0; i < wq_addr.size() && i < v.exp_writes; i++) begin
            check($sformatf("v%0d_addr%0d", idx, i), {28'd0, wq_addr[i]}, i);
            check($sformatf("v%0d_data%0d", idx, i), wq_data[i], word_data(v, i));
        end
        check($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
        check($sformatf("v%0d_busy_end", idx), {31'd0, busy}, 32'd0);
        if (v.exp_writes == 0) check($sformatf("v%0d_ready_seen", idx), {31'd0, ready_seen}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{wc: 5'd1,  base: 32'hDEADBEEF, step: 32'h0,        gaps: 0, exp_writes: 1};
        vecs[1] = '{wc: 5'd16, base: 32'h0,        step: 32'h11,       gaps: 1, exp_writes: 16};
        vecs[2] = '{wc: 5'd20, base: 32'hCAFE0000, step: 32'h00010203, gaps: 0, exp_writes: 16};
        vecs[3] = '{wc: 5'd0,  base: 32'h0,        step: 32'h0,        gaps: 0, exp_writes: 0};
        vecs[4] = '{wc: 5'd3,  base: 32'h80000001, step: 32'h13579BDF, gaps: 1, exp_writes: 3};
        vecs[5] = '{wc: 5'd31, base: 32'hFFFFFFFF, step: 32'hFEDCBA98, gaps: 1, exp_writes: 16};

        // Reset with a valid byte pending: nothing may be accepted.
        reset          = 1'b1;
        start          = 1'b0;
        word_count     = '0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hFF;
        tick();
        tick();
        @(negedge clk);
        check("rst_byte_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("rst_mem_we",     {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr",   {28'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata",  bus.mem_wdata, 32'd0);
        check("rst_fetch_hold", {31'd0, fetch_hold}, 32'd0);
        check("rst_busy",       {31'd0, busy}, 32'd0);
        check("rst_done",       {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        tick();

        // Single word, back-to-back bytes, cycle-exact.
        word_count = 5'd1;
        start      = 1'b1;
        @(negedge clk);
        check("t2_idle_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("t2_idle_busy",  {31'd0, busy}, 32'd0);
        tick();
        start          = 1'b0;
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hDE;
        @(negedge clk);
        check("t2_ready_1st", {31'd0, bus.byte_ready}, 32'd1);
        check("t2_hold_1st",  {31'd0, fetch_hold}, 32'd1);
        tick(); bus.byte_in = 8'hAD;
        tick(); bus.byte_in = 8'hBE;
        tick(); bus.byte_in = 8'hEF;
        tick(); bus.byte_valid = 1'b0;
        @(negedge clk);
        check("t2_we",         {31'd0, bus.mem_we}, 32'd1);
        check("t2_addr",       {28'd0, bus.mem_addr}, 32'd0);
        check("t2_wdata",      bus.mem_wdata, 32'hDEADBEEF);
        check("t2_ready_wr",   {31'd0, bus.byte_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("t2_done",       {31'd0, done}, 32'd1);
        check("t2_we_off",     {31'd0, bus.mem_we}, 32'd0);
        check("t2_hold_fin",   {31'd0, fetch_hold}, 32'd1);
        tick();
        @(negedge clk);
        check("t2_done_off",   {31'd0, done}, 32'd0);
        check("t2_hold_off",   {31'd0, fetch_hold}, 32'd0);
        check("t2_wdata_held", bus.mem_wdata, 32'hDEADBEEF);
        tick();

        // Zero-word load goes straight to FINISH.
        pulse_start(5'd0);
        @(negedge clk);
        check("n0_done",  {31'd0, done}, 32'd1);
        check("n0_ready", {31'd0, bus.byte_ready}, 32'd0);
        check("n0_busy",  {31'd0, busy}, 32'd1);
        tick();
        @(negedge clk);
        check("n0_done_off", {31'd0, done}, 32'd0);
        check("n0_busy_off", {31'd0, busy}, 32'd0);
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset after two bytes of the fourth word aborts without a write.
        clear_log();
        pulse_start(5'd5);
        for (int i = 0; i < 3; i++) send_word(32'hA0000000 + 32'(i), 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        reset = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("t5_writes",     wq_addr.size(), 3);
        check("t5_we",         {31'd0, bus.mem_we}, 32'd0);
        check("t5_wdata",      bus.mem_wdata, 32'd0);
        check("t5_addr",       {28'd0, bus.mem_addr}, 32'd0);
        check("t5_busy",       {31'd0, busy}, 32'd0);
        check("t5_ready",      {31'd0, bus.byte_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_log();
        pulse_start(5'd1);
        send_word(32'h12345678, 0);
        wait_done();
        check("t5_new_writes", wq_addr.size(), 1);
        if (wq_addr.size() > 0) begin
            check("t5_new_addr", {28'd0, wq_addr[0]}, 32'd0);
            check("t5_new_data", wq_data[0], 32'h12345678);
        end

        // start during COLLECT is ignored.
        clear_log();
        pulse_start(5'd2);
        send_word(32'h11223344, 0);
        tick();
        pulse_start(5'd16);
        send_word(32'h55667788, 1);
        wait_done();
        check("t6_writes",   wq_addr.size(), 2);
        if (wq_addr.size() == 2) begin
            check("t6_addr1", {28'd0, wq_addr[1]}, 32'd1);
            check("t6_data1", wq_data[1], 32'h55667788);
        end
        check("t6_done_cnt", done_cnt, 1);
        check("t6_busy_end", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
